// File: rtl/v_state_table_if.sv
// Shared configuration, list-state types and the lookup/writeback bundle
// between the context state table and the list-update datapath.

package cfg_pkg;
  localparam int CONTEXT_N = 4;
  localparam int ENTRIES_N = 4;
endpackage

package v_pkg;
  localparam int ID_W  = $clog2(cfg_pkg::CONTEXT_N);
  localparam int LS_W  = $clog2(cfg_pkg::ENTRIES_N + 1);

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic [LS_W-1:0]                          listsize;
    logic [cfg_pkg::ENTRIES_N-1:0]            vld;
    logic [cfg_pkg::ENTRIES_N-1:0][63:0]      key;
    logic [cfg_pkg::ENTRIES_N-1:0][31:0]      volume;
  } state_t;
endpackage

interface v_state_table_if;
  import v_pkg::*;

  logic   clr;
  logic   init_busy_r;
  logic   rd_vld;
  id_t    rd_id;
  logic   rd_rdy;
  logic   rsp_vld_r;
  id_t    rsp_id_r;
  state_t rsp_state_r;
  logic   wr_vld;
  id_t    wr_id;
  state_t wr_state;

  modport master (
    output clr, rd_vld, rd_id, wr_vld, wr_id, wr_state,
    input  init_busy_r, rd_rdy, rsp_vld_r, rsp_id_r, rsp_state_r
  );

  modport slave (
    input  clr, rd_vld, rd_id, wr_vld, wr_id, wr_state,
    output init_busy_r, rd_rdy, rsp_vld_r, rsp_id_r, rsp_state_r
  );
endinterface

// File: rtl/v_state_table.sv
// Per-context list-state table: one-cycle lookup with write-first bypass,
// writeback from the update datapath, and a clear sweep after reset or clr.

module v_state_table
  import v_pkg::*;
#(
  parameter int CONTEXT_N = cfg_pkg::CONTEXT_N,
  parameter int ENTRIES_N = cfg_pkg::ENTRIES_N
) (
  input  logic           clk,
  input  logic           arst_n,
  v_state_table_if.slave bus
);

  if (CONTEXT_N < 2 || CONTEXT_N > (1 << ID_W)) begin : g_bad_depth
    $error("v_state_table: CONTEXT_N out of range for id_t");
  end
  if (ENTRIES_N != cfg_pkg::ENTRIES_N) begin : g_bad_entries
    $error("v_state_table: ENTRIES_N must match state_t layout");
  end

  typedef enum logic {INIT = 1'b0, READY = 1'b1} fsm_e;

  localparam id_t LAST_IDX = id_t'(CONTEXT_N - 1);

  fsm_e   state_r, state_nxt;
  id_t    idx_r, idx_nxt;
  state_t mem [CONTEXT_N];
  state_t rd_data;
  logic   rd_fire, rd_in_range, wr_in_range, wr_en, wr_hit;

  assign bus.rd_rdy  = !bus.init_busy_r;
  assign rd_fire     = bus.rd_vld && bus.rd_rdy;
  assign rd_in_range = int'(bus.rd_id) < CONTEXT_N;
  assign wr_in_range = int'(bus.wr_id) < CONTEXT_N;
  assign wr_en       = bus.wr_vld && (state_r == READY) && wr_in_range;
  assign wr_hit      = wr_en && (bus.wr_id == bus.rd_id);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state_r;
    idx_nxt   = idx_r;
    unique case (state_r)
      INIT: begin
        idx_nxt = idx_r + id_t'(1);
        if (idx_r == LAST_IDX) begin
          state_nxt = READY;
          idx_nxt   = '0;
        end
      end
      READY: ;
      default: ;
    endcase
    if (bus.clr) begin
      state_nxt = INIT;
      idx_nxt   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r         <= INIT;
      idx_r           <= '0;
      bus.init_busy_r <= 1'b1;
    end else begin
      state_r         <= state_nxt;
      idx_r           <= idx_nxt;
      bus.init_busy_r <= (state_nxt == INIT);
    end
  end

  // NOTE: the array has no reset; the init sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (state_r == INIT) begin
      mem[idx_r] <= '0;
    end else if (wr_en) begin
      mem[bus.wr_id] <= bus.wr_state;
    end
  end

  // Same-cycle writeback to the looked-up id wins over the stored value.
  always_comb begin
    rd_data = '0;
    if (rd_in_range) begin
      rd_data = wr_hit ? bus.wr_state : mem[bus.rd_id];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bus.rsp_vld_r   <= 1'b0;
      bus.rsp_id_r    <= '0;
      bus.rsp_state_r <= '0;
    end else begin
      bus.rsp_vld_r <= rd_fire;
      if (rd_fire) begin
        bus.rsp_id_r    <= bus.rd_id;
        bus.rsp_state_r <= rd_data;
      end
    end
  end

`ifndef SYNTHESIS
  a_wr_in_init: assert property (@(posedge clk) disable iff (!arst_n)
    !(bus.wr_vld && state_r == INIT))
    else $warning("v_state_table: wr_vld during init sweep, write dropped");

  a_rd_range: assert property (@(posedge clk) disable iff (!arst_n)
    !(rd_fire && !rd_in_range))
    else $warning("v_state_table: rd_id beyond CONTEXT_N");

  a_wr_range: assert property (@(posedge clk) disable iff (!arst_n)
    !(bus.wr_vld && !wr_in_range))
    else $warning("v_state_table: wr_id beyond CONTEXT_N");
`endif

endmodule

// File: tb/tb_v_state_table.sv
// Bench for v_state_table: table-driven lookups/writebacks checked through a
// response scoreboard, plus hand sequences for clear, bypass and reset corners.

module tb_v_state_table;
  import v_pkg::*;

  localparam int CN = cfg_pkg::CONTEXT_N;
  localparam int EN = cfg_pkg::ENTRIES_N;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  v_state_table_if bus ();

  v_state_table #(.CONTEXT_N(CN), .ENTRIES_N(EN)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic   wr_vld;
    id_t    wr_id;
    state_t wr_state;
    logic   rd_vld;
    id_t    rd_id;
    state_t exp_state;
  } vec_t;

  typedef struct {
    id_t    id;
    state_t st;
  } exp_t;

  exp_t   sb_q[$];
  state_t model [CN];
  int     n_vec = 0;
  int     n_err = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic state_t mk(input int ls, input logic [63:0] k, input logic [31:0] v);
    state_t s;
    s           = '0;
    s.listsize  = LS_W'(ls);
    s.vld       = EN'((1 << ls) - 1);
    s.key[0]    = k;
    s.volume[0] = v;
    return s;
  endfunction

  function automatic vec_t mkv(input logic wv, input int wid, input state_t ws,
                               input logic rv, input int rid, input state_t ex);
    vec_t v;
    v.wr_vld    = wv;
    v.wr_id     = id_t'(wid);
    v.wr_state  = ws;
    v.rd_vld    = rv;
    v.rd_id     = id_t'(rid);
    v.exp_state = ex;
    return v;
  endfunction

  // Drives one cycle of stimulus, records the expected response if the
  // lookup will be accepted, and tracks writes that land in READY.
  task automatic drive(input logic wv, input id_t wid, input state_t ws,
                       input logic rv, input id_t rid, input state_t exp_st,
                       input logic clr_in);
    logic ready;
    ready        = bus.rd_rdy;
    bus.wr_vld   = wv;
    bus.wr_id    = wid;
    bus.wr_state = ws;
    bus.rd_vld   = rv;
    bus.rd_id    = rid;
    bus.clr      = clr_in;
    if (rv && ready) sb_q.push_back('{id: rid, st: exp_st});
    if (wv && ready) model[wid] = ws;
    @(posedge clk);
    #1;
    bus.wr_vld   = 1'b0;
    bus.wr_id    = '0;
    bus.wr_state = '0;
    bus.rd_vld   = 1'b0;
    bus.rd_id    = '0;
    bus.clr      = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.init_busy_r) cycles++;
      else break;
    end
  endtask

  always @(negedge clk) begin
    if (arst_n && bus.rsp_vld_r) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got id %0d with no lookup outstanding", bus.rsp_id_r);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_id", 512'(bus.rsp_id_r), 512'(e.id));
        check("rsp_state", 512'(bus.rsp_state_r), 512'(e.st));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t   tbl [13];
    state_t z, s_a, s_b, s_c, s_d, s_e;
    int     c;

    z   = '0;
    s_a = mk(3, 64'hA5, 32'd100);
    s_b = mk(1, 64'h3, 32'd33);
    s_c = mk(2, 64'h1234, 32'd7);
    s_d = mk(4, 64'hDEAD_BEEF, 32'd9);
    s_e = mk(1, 64'h55, 32'd1);

    tbl[0]  = mkv(0, 0, z,   1, 0, z);
    tbl[1]  = mkv(0, 0, z,   1, 1, z);
    tbl[2]  = mkv(0, 0, z,   1, 2, z);
    tbl[3]  = mkv(0, 0, z,   1, 3, z);
    tbl[4]  = mkv(1, 2, s_a, 0, 0, z);
    tbl[5]  = mkv(0, 0, z,   1, 2, s_a);
    tbl[6]  = mkv(0, 0, z,   1, 1, z);
    tbl[7]  = mkv(1, 3, s_b, 1, 3, s_b);
    tbl[8]  = mkv(1, 0, s_c, 1, 3, s_b);
    tbl[9]  = mkv(0, 0, z,   1, 0, s_c);
    tbl[10] = mkv(1, 1, s_d, 1, 2, s_a);
    tbl[11] = mkv(0, 0, z,   1, 1, s_d);
    tbl[12] = mkv(1, 1, s_e, 0, 0, z);

    for (int i = 0; i < CN; i++) model[i] = '0;
    bus.clr = 1'b0; bus.rd_vld = 1'b0; bus.rd_id = '0;
    bus.wr_vld = 1'b0; bus.wr_id = '0; bus.wr_state = '0;

    // Reset values and post-reset sweep length.
    repeat (3) @(posedge clk);
    #1;
    check("rst_init_busy", 512'(bus.init_busy_r), 512'(1));
    check("rst_rd_rdy", 512'(bus.rd_rdy), 512'(0));
    check("rst_rsp_vld", 512'(bus.rsp_vld_r), 512'(0));
    check("rst_rsp_id", 512'(bus.rsp_id_r), 512'(0));
    check("rst_rsp_state", 512'(bus.rsp_state_r), 512'(0));
    arst_n = 1'b1;
    wait_init(c);
    check("init_cycles", 512'(c), 512'(CN));

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].wr_vld, tbl[i].wr_id, tbl[i].wr_state,
            tbl[i].rd_vld, tbl[i].rd_id, tbl[i].exp_state, 1'b0);
    end
    // The id 1 write in the response cycle must not disturb the held response.
    check("rsp_hold_vld", 512'(bus.rsp_vld_r), 512'(0));
    check("rsp_hold_state", 512'(bus.rsp_state_r), 512'(s_d));
    drive(1'b0, '0, '0, 1'b1, id_t'(1), s_e, 1'b0);
    idle();

    // Back-to-back lookups: response valid on four consecutive cycles.
    for (int i = 0; i < CN; i++) begin
      drive(1'b0, '0, '0, 1'b1, id_t'(i), model[i], 1'b0);
      check("b2b_rsp_vld", 512'(bus.rsp_vld_r), 512'(1));
    end
    idle();
    check("b2b_rsp_drop", 512'(bus.rsp_vld_r), 512'(0));

    // Clear sweep with a lookup in the clr cycle and a write during the sweep.
    for (int i = 0; i < CN; i++)
      drive(1'b1, id_t'(i), mk(i + 1, 64'hF0 + 64'(i), 32'(10 * i + 5)), 1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, id_t'(2), model[2], 1'b1);
    for (int i = 0; i < CN; i++) model[i] = '0;
    c = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.rd_rdy) break;
      c++;
      if (c == 2) drive(1'b1, id_t'(0), mk(4, 64'h77, 32'd77), 1'b0, '0, '0, 1'b0);
      else idle();
    end
    check("clr_busy_cycles", 512'(c), 512'(CN));
    for (int i = 0; i < CN; i++) drive(1'b0, '0, '0, 1'b1, id_t'(i), model[i], 1'b0);
    idle();

    // Reset during a sweep with a response in flight.
    drive(1'b1, id_t'(1), s_a, 1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, id_t'(1), model[1], 1'b1);
    check("pend_rsp_vld", 512'(bus.rsp_vld_r), 512'(1));
    arst_n = 1'b0;
    #1;
    sb_q.delete();
    for (int i = 0; i < CN; i++) model[i] = '0;
    check("arst_rsp_vld", 512'(bus.rsp_vld_r), 512'(0));
    check("arst_init_busy", 512'(bus.init_busy_r), 512'(1));
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    wait_init(c);
    check("rearm_init_cycles", 512'(c), 512'(CN));
    for (int i = 0; i < CN; i++) drive(1'b0, '0, '0, 1'b1, id_t'(i), model[i], 1'b0);
    idle();
    idle();
    check("sb_drained", 512'(sb_q.size()), 512'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
